// File: rtl/apb_irq_status_regs.sv
// APB interrupt status block: NUM_CH synchronised event inputs captured into W1C STATUS bits,
// with enable mask, registered irq and a saturating event counter. Define IRQ_STATUS_SET_EN to map SET (0x14).
module apb_irq_status_regs #(
    parameter int unsigned       ADDR_WIDTH   = 8,
    parameter int unsigned       NUM_CH       = 8,
    parameter logic [NUM_CH-1:0] EDGE_MASK    = {NUM_CH{1'b1}},
    parameter logic [NUM_CH-1:0] ENABLE_RESET = '0,
    parameter int unsigned       CNT_WIDTH    = 16
) (
    input  logic                  RegClk,
    input  logic                  RegReset,
    input  logic [NUM_CH-1:0]     evt_in,
    output logic                  irq,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int unsigned DATA_W   = 32;
    localparam logic [2:0]  A_STATUS = 3'd0;
    localparam logic [2:0]  A_ENABLE = 3'd1;
    localparam logic [2:0]  A_PEND   = 3'd2;
    localparam logic [2:0]  A_RAW    = 3'd3;
    localparam logic [2:0]  A_COUNT  = 3'd4;
`ifdef IRQ_STATUS_SET_EN
    localparam logic [2:0]  A_SET    = 3'd5;
`endif

    logic [NUM_CH-1:0]    s1, s2, s3;
    logic [NUM_CH-1:0]    status, enable;
    logic [NUM_CH-1:0]    cap, clr, set_bits, status_next, wdata_ch;
    logic [CNT_WIDTH-1:0] count;
    logic [2:0]           idx;
    logic                 access, wr, mapped, new_assert, cnt_clr;
    logic                 unused_bits;

    assign access   = PSEL & PENABLE;
    assign idx      = PADDR[4:2];
    assign wr       = access & PWRITE & mapped;
    assign wdata_ch = PWDATA[NUM_CH-1:0];
    assign PREADY   = 1'b1;
    assign PSLVERR  = access & ~mapped;
    // Address bits outside [4:2] and data bits above NUM_CH are intentionally ignored.
    assign unused_bits = ^{PADDR, PWDATA};

    // Address decode
    always_comb begin
        mapped = 1'b0;
        case (idx)
            A_STATUS, A_ENABLE, A_PEND, A_RAW, A_COUNT: mapped = 1'b1;
`ifdef IRQ_STATUS_SET_EN
            A_SET:                                      mapped = 1'b1;
`endif
            default:                                    mapped = 1'b0;
        endcase
    end

    // Edge channels capture the s2 rising edge; level channels capture s2 directly.
    assign cap = (s2 & ~s3 & EDGE_MASK) | (s2 & ~EDGE_MASK);
    assign clr = (wr && idx == A_STATUS) ? wdata_ch : '0;
`ifdef IRQ_STATUS_SET_EN
    assign set_bits = (wr && idx == A_SET) ? wdata_ch : '0;
`else
    assign set_bits = '0;
`endif

    // Capture and set both win over a same-cycle clear.
    assign status_next = cap | set_bits | (status & ~clr);
    assign new_assert  = |((cap | set_bits) & ~status);
    assign cnt_clr     = wr && idx == A_COUNT;

    // Synchroniser and history flops
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= evt_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Status, enable, counter and interrupt registers
    always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
            status <= '0;
            enable <= ENABLE_RESET;
            count  <= '0;
            irq    <= 1'b0;
        end else begin
            status <= status_next;
            irq    <= |(status & enable);
            if (wr && idx == A_ENABLE) begin
                enable <= wdata_ch;
            end
            if (cnt_clr) begin
                count <= new_assert ? CNT_WIDTH'(1) : '0;
            end else if (new_assert && count != '1) begin
                count <= count + CNT_WIDTH'(1);
            end
        end
    end

    // Read mux, combinational from PADDR
    always_comb begin
        PRDATA = '0;
        case (idx)
            A_STATUS: PRDATA = DATA_W'(status);
            A_ENABLE: PRDATA = DATA_W'(enable);
            A_PEND:   PRDATA = DATA_W'(status & enable);
            A_RAW:    PRDATA = DATA_W'(s2);
            A_COUNT:  PRDATA = DATA_W'(count);
            default:  PRDATA = '0;
        endcase
    end

endmodule
